uart_param: RTL and testbench

UART_PARAM -- requirements
Module: uart_param

---
 rtl/uart_param.sv | 257 +++++++++++++++++++++++++
 tb/tb_uart_param.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_param.sv
// uart_param: parameterised full-duplex UART.
// Frame = start(0), DATA_BITS LSB first, optional odd/even parity, STOP_BITS stop(1).
// RX and TX are independent state machines sharing only clk and reset.
module uart_param #(
  parameter int CLK_DIV   = 868,  // clock cycles per bit period (8..65535)
  parameter int DATA_BITS = 8,    // data bits per frame (5..9)
  parameter int PARITY    = 0,    // 0 none, 1 odd, 2 even
  parameter int STOP_BITS = 1     // 1 or 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_out
);

  localparam int               CNT_W     = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam bit               HAS_PAR   = (PARITY != 0);

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_PAR   = 3'd3;
  localparam logic [2:0] RX_STOP  = 3'd4;
  localparam logic [2:0] RX_DONE  = 3'd5;

  localparam logic [2:0] TX_IDLE  = 3'd0;
  localparam logic [2:0] TX_START = 3'd1;
  localparam logic [2:0] TX_DATA  = 3'd2;
  localparam logic [2:0] TX_PAR   = 3'd3;
  localparam logic [2:0] TX_STOP  = 3'd4;

  // ---------------------------------------------------------------- RX
  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [2:0]           rx_state_q, rx_state_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [3:0]           rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rx_facc_q, rx_facc_d;
  logic                 rx_armed_q, rx_armed_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_par_bad;

  assign rx_s = sync_q[1];

  // Two-flop synchroniser for the asynchronous receive line.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: reset to 1 (line idle) so leaving reset never looks like a start bit.
    if (!reset) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx_in};
  end

  // Parity check over the received data plus parity bit.
  always_comb begin
    rx_par_bad = 1'b0;
    if (PARITY == 1)      rx_par_bad = ~(^{rx_shift_q, rx_par_q});
    else if (PARITY == 2) rx_par_bad = ^{rx_shift_q, rx_par_q};
  end

  // RX next-state: mid-bit sampling, glitch rejection, break re-arm.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_facc_d  = rx_facc_q;
    rx_armed_d = rx_armed_q;
    rx_data_d  = rx_data_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_s)            rx_armed_d = 1'b1;
        else if (rx_armed_q) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == HALF_LAST) begin
        rx_cnt_d  = '0;
        rx_idx_d  = '0;
        rx_facc_d = 1'b0;
        rx_state_d = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
        if (rx_idx_q == DATA_LAST) begin
          rx_idx_d   = '0;
          rx_state_d = HAS_PAR ? RX_PAR : RX_STOP;
        end else begin
          rx_idx_d = rx_idx_q + 4'd1;
        end
      end
      RX_PAR: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rx_par_d   = rx_s;
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d = '0;
        if (!rx_s) rx_facc_d = 1'b1;
        if (rx_idx_q == STOP_LAST) begin
          rx_state_d = RX_DONE;
          rx_data_d  = rx_shift_q;
          rx_perr_d  = rx_par_bad;
          rx_ferr_d  = rx_facc_q | ~rx_s;
        end else begin
          rx_idx_d = rx_idx_q + 4'd1;
        end
      end
      RX_DONE: begin
        rx_cnt_d   = '0;
        rx_armed_d = 1'b0;  // a held-low line must go high before the next start
        rx_state_d = RX_IDLE;
      end
      default: begin
        rx_cnt_d   = '0;
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  // RX state registers.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments so all flops update together on the edge.
    if (!reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_facc_q  <= 1'b0;
      rx_armed_q <= 1'b0;
      rx_data_q  <= '0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      rx_facc_q  <= rx_facc_d;
      rx_armed_q <= rx_armed_d;
      rx_data_q  <= rx_data_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  assign rx_valid      = (rx_state_q == RX_DONE);
  assign rx_data       = rx_data_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;

  // ---------------------------------------------------------------- TX
  logic [2:0]           tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [3:0]           tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;

  // TX next-state: accept in IDLE, then hold each bit for CLK_DIV cycles.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        tx_idx_d = '0;
        if (tx_valid) begin
          tx_shift_d = tx_data;
          tx_par_d   = (PARITY == 1) ? ~(^tx_data) : ^tx_data;
          tx_state_d = TX_START;
        end
      end
      TX_START: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_idx_d   = '0;
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
        if (tx_idx_q == DATA_LAST) begin
          tx_idx_d   = '0;
          tx_state_d = HAS_PAR ? TX_PAR : TX_STOP;
        end else begin
          tx_idx_d = tx_idx_q + 4'd1;
        end
      end
      TX_PAR: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_idx_d   = '0;
        tx_state_d = TX_STOP;
      end
      TX_STOP: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        if (tx_idx_q == STOP_LAST) tx_state_d = TX_IDLE;
        else                       tx_idx_d   = tx_idx_q + 4'd1;
      end
      default: begin
        tx_cnt_d   = '0;
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  // TX state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
    end
  end

  // Line driver decoded from registered state; idle and stop are high.
  always_comb begin
    tx_out = 1'b1;
    case (tx_state_q)
      TX_START: tx_out = 1'b0;
      TX_DATA:  tx_out = tx_shift_q[0];
      TX_PAR:   tx_out = tx_par_q;
      default:  tx_out = 1'b1;
    endcase
  end

  assign tx_ready = (tx_state_q == TX_IDLE);

endmodule

// File: tb/tb_uart_param.sv
// Self-checking bench for uart_param: three instances at CLK_DIV=16
//   a: 8N1 (TX and RX driven by the bench)
//   b: 7E2 with tx_out looped back to rx_in
//   c: 8O1 (TX and RX driven by the bench)
`timescale 1ns/1ps
module tb_uart_param;
  localparam int DIV = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // instance a
  logic       rx_a, tx_valid_a, tx_ready_a, tx_out_a, rx_valid_a, pe_a, fe_a;
  logic [7:0] txd_a, rxd_a;
  // instance b
  logic       tx_valid_b, tx_ready_b, tx_out_b, rx_valid_b, pe_b, fe_b;
  logic [6:0] txd_b, rxd_b;
  // instance c
  logic       rx_c, tx_valid_c, tx_ready_c, tx_out_c, rx_valid_c, pe_c, fe_c;
  logic [7:0] txd_c, rxd_c;

  uart_param #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .reset(reset), .rx_in(rx_a), .rx_valid(rx_valid_a), .rx_data(rxd_a),
    .rx_parity_err(pe_a), .rx_frame_err(fe_a), .tx_valid(tx_valid_a), .tx_data(txd_a),
    .tx_ready(tx_ready_a), .tx_out(tx_out_a));

  uart_param #(.CLK_DIV(DIV), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
    .clk(clk), .reset(reset), .rx_in(tx_out_b), .rx_valid(rx_valid_b), .rx_data(rxd_b),
    .rx_parity_err(pe_b), .rx_frame_err(fe_b), .tx_valid(tx_valid_b), .tx_data(txd_b),
    .tx_ready(tx_ready_b), .tx_out(tx_out_b));

  uart_param #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_c (
    .clk(clk), .reset(reset), .rx_in(rx_c), .rx_valid(rx_valid_c), .rx_data(rxd_c),
    .rx_parity_err(pe_c), .rx_frame_err(fe_c), .tx_valid(tx_valid_c), .tx_data(txd_c),
    .tx_ready(tx_ready_c), .tx_out(tx_out_c));

  // ---------------------------------------------------------------- config / access
  function automatic int db_of(int i);  return (i == 1) ? 7 : 8; endfunction
  function automatic int par_of(int i); return (i == 0) ? 0 : (i == 1) ? 2 : 1; endfunction
  function automatic int sb_of(int i);  return (i == 1) ? 2 : 1; endfunction
  function automatic int frame_len(int i);
    return 1 + db_of(i) + ((par_of(i) != 0) ? 1 : 0) + sb_of(i);
  endfunction
  function automatic logic [8:0] mask_of(int i);
    return (i == 1) ? 9'h07f : 9'h0ff;
  endfunction

  function automatic logic tx_out_of(int i);
    return (i == 0) ? tx_out_a : (i == 1) ? tx_out_b : tx_out_c;
  endfunction
  function automatic logic tx_ready_of(int i);
    return (i == 0) ? tx_ready_a : (i == 1) ? tx_ready_b : tx_ready_c;
  endfunction
  function automatic logic rx_valid_of(int i);
    return (i == 0) ? rx_valid_a : (i == 1) ? rx_valid_b : rx_valid_c;
  endfunction
  function automatic logic pe_of(int i);
    return (i == 0) ? pe_a : (i == 1) ? pe_b : pe_c;
  endfunction
  function automatic logic fe_of(int i);
    return (i == 0) ? fe_a : (i == 1) ? fe_b : fe_c;
  endfunction
  function automatic logic [8:0] rxd_of(int i);
    return (i == 0) ? {1'b0, rxd_a} : (i == 1) ? {2'b00, rxd_b} : {1'b0, rxd_c};
  endfunction

  task automatic set_tx(input int i, input logic v, input logic [8:0] d);
    case (i)
      0:       begin tx_valid_a = v; txd_a = d[7:0]; end
      1:       begin tx_valid_b = v; txd_b = d[6:0]; end
      default: begin tx_valid_c = v; txd_c = d[7:0]; end
    endcase
  endtask

  task automatic set_rx(input int i, input logic v);
    if (i == 0) rx_a = v;
    else        rx_c = v;
  endtask

  // ---------------------------------------------------------------- reference model
  // Line level of frame bit k for word d: start, data LSB first, parity, stops.
  function automatic logic frame_bit(int i, logic [8:0] d, int k, bit bad_par, bit stop_v);
    int n;
    int ones;
    n = db_of(i);
    if (k == 0) return 1'b0;
    if (k <= n) return d[k-1];
    if (par_of(i) != 0 && k == n + 1) begin
      ones = 0;
      for (int b = 0; b < n; b++) ones += int'(d[b]);
      // parity bit chosen so total ones (data + parity) is odd / even
      if (par_of(i) == 1) return ((ones % 2) == 0) ^ bad_par;
      else                return ((ones % 2) == 1) ^ bad_par;
    end
    return stop_v;
  endfunction

  // ---------------------------------------------------------------- rx_valid monitor
  int         vcnt  [3] = '{0, 0, 0};
  logic [8:0] cap_d [3];
  logic       cap_pe[3];
  logic       cap_fe[3];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rx_valid_of(i) === 1'b1) begin
        vcnt[i]   <= vcnt[i] + 1;
        cap_d[i]  <= rxd_of(i);
        cap_pe[i] <= pe_of(i);
        cap_fe[i] <= fe_of(i);
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  // Watch ncyc cycles of a transmit frame from the first start-bit cycle;
  // counts cycles where tx_out or tx_ready disagree with the model.
  task automatic watch_tx(input int i, input logic [8:0] d, input int ncyc,
                          output int bad, output logic [15:0] seen);
    bad  = 0;
    seen = '0;
    for (int k = 0; k < ncyc; k++) begin
      if (tx_out_of(i) !== frame_bit(i, d, k / DIV, 1'b0, 1'b1)) bad++;
      if (tx_ready_of(i) !== 1'b0) bad++;
      if (k % DIV == DIV / 2) seen[k / DIV] = tx_out_of(i);
      @(negedge clk);
    end
  endtask

  task automatic drive_frame(input int i, input logic [8:0] d, input bit bad_par, input bit stop_v);
    for (int k = 0; k < frame_len(i); k++) begin
      set_rx(i, frame_bit(i, d, k, bad_par, stop_v));
      repeat (DIV) @(negedge clk);
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    reset = 1'b0;
    rx_a = 1'b1; rx_c = 1'b1;
    for (int i = 0; i < 3; i++) set_tx(i, 1'b0, 9'h0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({tx_out_of(i), tx_ready_of(i), rx_valid_of(i), pe_of(i), fe_of(i), rxd_of(i)} !== {5'b11000, 9'h0}) begin
        errors++;
        $display("FAIL reset_state[%0d]: got out=%b rdy=%b val=%b pe=%b fe=%b data=%h, want 1 1 0 0 0 000",
                 i, tx_out_of(i), tx_ready_of(i), rx_valid_of(i), pe_of(i), fe_of(i), rxd_of(i));
      end
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({tx_ready_a, tx_ready_b, tx_ready_c} !== 3'b111) begin
      errors++;
      $display("FAIL ready_after_release: got %b want 111", {tx_ready_a, tx_ready_b, tx_ready_c});
    end
  endtask

  // One complete transmit frame on instance i, checked cycle by cycle.
  task automatic test_tx(input int i, input logic [8:0] d, output logic [15:0] seen);
    int bad;
    @(negedge clk);
    checks++;
    if (tx_ready_of(i) !== 1'b1) begin
      errors++;
      $display("FAIL tx_ready_before[%0d]: got %b want 1", i, tx_ready_of(i));
    end
    set_tx(i, 1'b1, d);
    @(negedge clk);
    set_tx(i, 1'b0, ~d);  // must be ignored while busy
    watch_tx(i, d, frame_len(i) * DIV, bad, seen);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL tx_wave[%0d] data=%h: got %0d bad cycles want 0", i, d, bad);
    end
    checks++;
    if ({tx_ready_of(i), tx_out_of(i)} !== 2'b11) begin
      errors++;
      $display("FAIL tx_end[%0d]: got ready/out=%b want 11", i, {tx_ready_of(i), tx_out_of(i)});
    end
  endtask

  task automatic test_tx_a5();
    logic [15:0] seen;
    test_tx(0, 9'h0a5, seen);
    checks++;
    if (seen[9:0] !== 10'b1101001010) begin
      errors++;
      $display("FAIL tx_a5_bits: got %b want 1101001010 (bit0 first from right)", seen[9:0]);
    end
  endtask

  task automatic test_tx_random();
    logic [15:0] seen;
    for (int n = 0; n < 3; n++) begin
      test_tx(0, 9'($urandom) & mask_of(0), seen);
      test_tx(2, 9'($urandom) & mask_of(2), seen);
    end
  endtask

  task automatic test_loopback(input logic [8:0] d);
    logic [15:0] seen;
    int base;
    base = vcnt[1];
    test_tx(1, d, seen);
    repeat (20) @(negedge clk);
    checks++;
    if (vcnt[1] - base !== 1) begin
      errors++;
      $display("FAIL loop_count: got %0d want 1", vcnt[1] - base);
    end
    checks++;
    if ({cap_d[1], cap_pe[1], cap_fe[1]} !== {d & mask_of(1), 2'b00}) begin
      errors++;
      $display("FAIL loop_data: got %h pe=%b fe=%b want %h 0 0", cap_d[1], cap_pe[1], cap_fe[1], d & mask_of(1));
    end
  endtask

  task automatic test_rx(input int i, input logic [8:0] d, input bit bad_par, input bit stop_v);
    int  base;
    logic exp_pe;
    base   = vcnt[i];
    exp_pe = (par_of(i) != 0) && bad_par;
    drive_frame(i, d, bad_par, stop_v);
    set_rx(i, 1'b1);
    repeat (3 * DIV) @(negedge clk);
    checks++;
    if (vcnt[i] - base !== 1) begin
      errors++;
      $display("FAIL rx_count[%0d]: got %0d want 1", i, vcnt[i] - base);
    end
    checks++;
    if ({cap_d[i], cap_pe[i], cap_fe[i]} !== {d, exp_pe, ~stop_v}) begin
      errors++;
      $display("FAIL rx_word[%0d]: got %h pe=%b fe=%b want %h pe=%b fe=%b",
               i, cap_d[i], cap_pe[i], cap_fe[i], d, exp_pe, ~stop_v);
    end
    checks++;
    if (rxd_of(i) !== d) begin
      errors++;
      $display("FAIL rx_hold[%0d]: got %h want %h", i, rxd_of(i), d);
    end
  endtask

  task automatic test_rx_random();
    for (int n = 0; n < 3; n++) begin
      test_rx(0, 9'($urandom) & mask_of(0), 1'b0, 1'($urandom_range(0, 3) != 0));
      test_rx(2, 9'($urandom) & mask_of(2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    end
  endtask

  task automatic test_glitch();
    int base;
    base = vcnt[0];
    @(negedge clk);
    rx_a = 1'b0;
    repeat (3) @(negedge clk);
    rx_a = 1'b1;
    repeat (4 * DIV) @(negedge clk);
    checks++;
    if (vcnt[0] - base !== 0) begin
      errors++;
      $display("FAIL glitch_count: got %0d want 0", vcnt[0] - base);
    end
    test_rx(0, 9'h012, 1'b0, 1'b1);
  endtask

  task automatic test_break();
    int base;
    base = vcnt[0];
    drive_frame(0, 9'h081, 1'b0, 1'b0);  // leaves line low
    repeat (40 * DIV) @(negedge clk);
    checks++;
    if (vcnt[0] - base !== 1) begin
      errors++;
      $display("FAIL break_count: got %0d want 1", vcnt[0] - base);
    end
    checks++;
    if ({cap_d[0], cap_fe[0]} !== {9'h081, 1'b1}) begin
      errors++;
      $display("FAIL break_word: got %h fe=%b want 081 fe=1", cap_d[0], cap_fe[0]);
    end
    rx_a = 1'b1;
    repeat (4 * DIV) @(negedge clk);
    checks++;
    if (vcnt[0] - base !== 1) begin
      errors++;
      $display("FAIL break_rearm: got %0d want 1", vcnt[0] - base);
    end
    test_rx(0, 9'($urandom) & mask_of(0), 1'b0, 1'b1);
  endtask

  task automatic test_reset_rx();
    int base;
    base = vcnt[2];
    @(negedge clk);
    rx_c = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rxd_of(2), pe_of(2), fe_of(2)} !== 11'h0) begin
      errors++;
      $display("FAIL reset_rx_clear: got %h pe=%b fe=%b want 000 0 0", rxd_of(2), pe_of(2), fe_of(2));
    end
    rx_c  = 1'b1;
    reset = 1'b1;
    repeat (12 * DIV) @(negedge clk);
    checks++;
    if (vcnt[2] - base !== 0) begin
      errors++;
      $display("FAIL reset_rx_count: got %0d want 0", vcnt[2] - base);
    end
  endtask

  task automatic test_back_to_back();
    int          bad;
    logic [15:0] seen;
    @(negedge clk);
    set_tx(0, 1'b1, 9'h001);
    @(negedge clk);
    txd_a = 8'h02;  // next word, held valid; ignored until ready
    watch_tx(0, 9'h001, frame_len(0) * DIV, bad, seen);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL b2b_first: got %0d bad cycles want 0", bad);
    end
    checks++;
    if ({tx_ready_a, tx_out_a} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_gap: got ready/out=%b want 11", {tx_ready_a, tx_out_a});
    end
    @(negedge clk);
    watch_tx(0, 9'h002, 4 * DIV + 5, bad, seen);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL b2b_second: got %0d bad cycles want 0", bad);
    end
    reset      = 1'b0;
    tx_valid_a = 1'b0;
    #1;
    checks++;
    if ({tx_out_a, tx_ready_a} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_abort: got out/ready=%b want 11", {tx_out_a, tx_ready_a});
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({tx_out_a, tx_ready_a} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_after_reset: got out/ready=%b want 11", {tx_out_a, tx_ready_a});
    end
  endtask

  initial begin
    test_reset();
    test_tx_a5();
    test_tx_random();
    test_loopback(9'h055);
    for (int n = 0; n < 2; n++) test_loopback(9'($urandom) & mask_of(1));
    test_rx(2, 9'h03c, 1'b1, 1'b1);
    test_rx_random();
    test_glitch();
    test_break();
    test_reset_rx();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
